// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bundle between the memory stage and dmem_responder
//  req_valid/req_ready : request handshake, transfer when both high
//  req_we/addr/wdata/be: store flag, byte address, store data, store byte enables
//  rsp_valid           : one-cycle response pulse, no back-pressure
//  rsp_rdata/rsp_err   : load data and access error, qualified by rsp_valid
//  master modport = memory stage side, slave modport = responder side
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory target with fixed-latency response
//  Parameters: DEPTH_WORDS (32-bit words, power of two >= 2), LATENCY (BUSY cycles, 0..15)
//  Ports: clk (rising edge), reset (asynchronous, active low), bus (dmem_responder_if.slave)
//  Optional feature macro: DMEM_ERR_CHECK_EN flags misaligned or out-of-range accesses
//  as errors; without it, rsp_err is 0 and the word index wraps modulo DEPTH_WORDS.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          go_resp;
    logic          mem_wr;
    logic          op_we;
    logic          op_err;
    logic [31:0]   op_addr;
    logic [31:0]   op_wdata;
    logic [3:0]    op_be;
    logic [AW-1:0] op_idx;

    // With LATENCY=0 the access completes on the transfer edge itself, so the
    // operation comes straight from the bus in IDLE and from the capture
    // registers once the request has been accepted.
    assign op_we    = (state_q == IDLE) ? bus.req_we    : we_q;
    assign op_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
    assign op_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
    assign op_be    = (state_q == IDLE) ? bus.req_be    : be_q;
    assign op_idx   = op_addr[AW+1:2];

`ifdef DMEM_ERR_CHECK_EN
    assign op_err = (op_addr[1:0] != 2'b00) || (|op_addr[31:AW+2]);
`else
    logic unused_addr_bits;
    assign op_err           = 1'b0;
    assign unused_addr_bits = ^{op_addr[1:0], op_addr[31:AW+2]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        go_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    if (LATENCY > 0) begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Response data is sampled on the edge entering RESP and then held
        // until the next response overwrites it.
        if (go_resp) begin
            err_d   = op_err;
            rdata_d = (op_we || op_err) ? 32'h0 : mem[op_idx];
        end
    end

    // Gated by reset so a transfer seen while reset is low never commits.
    assign mem_wr = go_resp && op_we && !op_err && reset;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (op_be[i]) mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule
